// File: rtl/minute_counter.sv
// Minutes stage: 00..59 on sec_carry edges, equal60 carry to hours, debounced manual adjust; 1-cycle update latency.
// Define MINUTE_AUTO_REPEAT_EN to add hold-to-repeat stepping; without it each debounced press steps exactly once.
module minute_counter #(
  parameter int RESET_VAL       = 59,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       sec_carry,
  input  logic       adj_sel,
  input  logic       btn_n,
  input  logic       dir,
  output logic       equal60,
  output logic       disable_hour,
  output logic [6:0] led2,
  output logic [6:0] led1
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD
`ifdef MINUTE_AUTO_REPEAT_EN
    , S_REPEAT
`endif
  } state_t;

  logic [5:0]      r_count;
  logic            r_equal60;
  logic            r_disable;
  logic            r_sec_prev;
  logic            r_sync1, r_sync2;
  logic            r_db, r_db_prev;
  logic [DB_W-1:0] r_db_cnt;
  state_t          r_state;
  state_t          w_next;
  logic            w_step;
  logic            w_tick;
  logic            w_press;
  logic [3:0]      w_tens, w_ones;

  assign w_tick  = sec_carry & ~r_sec_prev;
  assign w_press = r_db_prev & ~r_db;

  // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_db      <= 1'b1;
      r_db_prev <= 1'b1;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= btn_n;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      if (r_sync2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_db     <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

`ifdef MINUTE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RT_W    = $clog2(RPT_MAX + 1);
  logic [RT_W-1:0] r_rpt_tmr;

  // Timer restarts on every step or state change, so it measures time since the last step.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_rpt_tmr <= '0;
    end else if (w_step || (w_next != r_state) || (r_state == S_IDLE)) begin
      r_rpt_tmr <= '0;
    end else if (r_rpt_tmr != {RT_W{1'b1}}) begin
      r_rpt_tmr <= r_rpt_tmr + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_step = 1'b1;
          w_next = S_HELD;
        end
      end
      S_HELD: begin
        if (r_db) begin
          w_next = S_IDLE;
        end
`ifdef MINUTE_AUTO_REPEAT_EN
        else if (r_rpt_tmr == RT_W'(REPEAT_DELAY - 1)) begin
          w_step = 1'b1;
          w_next = S_REPEAT;
        end
      end
      S_REPEAT: begin
        if (r_db) begin
          w_next = S_IDLE;
        end else if (r_rpt_tmr == RT_W'(REPEAT_PERIOD - 1)) begin
          w_step = 1'b1;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Ticks and steps are mutually exclusive: the registered adjust flag picks the source.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_count    <= 6'(RESET_VAL);
      r_equal60  <= 1'b0;
      r_disable  <= 1'b0;
      r_sec_prev <= 1'b0;
    end else begin
      r_sec_prev <= sec_carry;
      r_disable  <= adj_sel;
      r_equal60  <= 1'b0;
      if (!r_disable) begin
        if (w_tick) begin
          if (r_count == 6'd59) begin
            r_count   <= 6'd0;
            r_equal60 <= 1'b1;
          end else begin
            r_count <= r_count + 6'd1;
          end
        end
      end else if (w_step) begin
        if (dir) r_count <= (r_count == 6'd59) ? 6'd0  : r_count + 6'd1;
        else     r_count <= (r_count == 6'd0)  ? 6'd59 : r_count - 6'd1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign w_tens = 4'(r_count / 6'd10);
  assign w_ones = 4'(r_count % 6'd10);

  assign led2         = seg7(w_tens);
  assign led1         = seg7(w_ones);
  assign equal60      = r_equal60;
  assign disable_hour = r_disable;

endmodule

// File: tb/tb_minute_counter.sv
// Bench for minute_counter: directed scenarios plus random stimulus checked each cycle against a behavioural model.
module tb_minute_counter;
  localparam int RV  = 59;
  localparam int DBC = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;

  logic clk50 = 1'b0;
  logic reset = 1'b0;
  logic sec_carry = 1'b0;
  logic adj_sel = 1'b0;
  logic btn_n = 1'b1;
  logic dir = 1'b1;
  wire       equal60, disable_hour;
  wire [6:0] led2, led1;

  minute_counter #(
    .RESET_VAL(RV), .DEBOUNCE_CYCLES(DBC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk50(clk50), .reset(reset), .sec_carry(sec_carry), .adj_sel(adj_sel),
    .btn_n(btn_n), .dir(dir), .equal60(equal60), .disable_hour(disable_hour),
    .led2(led2), .led1(led1)
  );

  always #10 clk50 = ~clk50;

  int total = 0;
  int bad   = 0;
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model: minute value as an integer, button as a sample history plus hold age.
  int m_count, m_run, m_age;
  bit m_eq, m_dh, m_sec_prev, m_db, m_db_prev, m_held;
  bit m_q[$];

  function automatic void model_reset();
    m_count = RV; m_eq = 0; m_dh = 0; m_sec_prev = 0;
    m_db = 1; m_db_prev = 1; m_held = 0; m_run = 0; m_age = 0;
    m_q = '{1'b1, 1'b1};
  endfunction

  function automatic void model_edge();
    bit s2, step, tick, press;
    s2 = m_q.pop_front();
    m_q.push_back(btn_n);
    press = m_db_prev && !m_db;
    step  = 0;
    if (!m_held) begin
      if (press) begin step = 1; m_held = 1; m_age = 0; end
    end else if (m_db) begin
      m_held = 0;
    end else begin
      m_age++;
`ifdef MINUTE_AUTO_REPEAT_EN
      if (m_age >= RD && ((m_age - RD) % RP) == 0) step = 1;
`endif
    end
    tick = sec_carry && !m_sec_prev;
    m_eq = 0;
    if (!m_dh) begin
      if (tick) begin
        if (m_count == 59) begin m_count = 0; m_eq = 1; end
        else m_count++;
      end
    end else if (step) begin
      m_count = dir ? (m_count + 1) % 60 : (m_count + 59) % 60;
    end
    m_db_prev = m_db;
    if (s2 != m_db) begin
      m_run++;
      if (m_run == DBC) begin m_db = s2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_dh = adj_sel;
    m_sec_prev = sec_carry;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("led2", led2, seg_tab[m_count / 10]);
    chk("led1", led1, seg_tab[m_count % 10]);
    chk("equal60", equal60, m_eq);
    chk("disable_hour", disable_hour, m_dh);
  endtask

  task automatic cyc();
    @(posedge clk50);
    if (reset) model_edge();
    else       model_reset();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input int low_n, input int high_n);
    btn_n = 1'b0;
    run(low_n);
    btn_n = 1'b1;
    run(high_n);
  endtask

  initial begin
    int pulses;
    model_reset();
    #25;
    check_all();
    @(negedge clk50);
    reset = 1'b1;

    // Scenario 1: first tick wraps the reset value and carries.
    sec_carry = 1'b1;
    cyc();
    chk("t1_equal60", equal60, 1);
    chk("t1_led2", led2, 7'b1000000);
    chk("t1_led1", led1, 7'b1000000);
    // Scenario 2: a long-high carry is one edge; then a full lap gives one pulse.
    run(9);
    chk("t2_hold_led1", led1, 7'b1000000);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      sec_carry = 1'b0; cyc();
      sec_carry = 1'b1; cyc();
      if (equal60 === 1'b1) pulses++;
    end
    chk("t2_pulses", pulses, 1);
    chk("t2_led2", led2, 7'b1000000);
    sec_carry = 1'b0;

    // Scenario 3/4: adjust mode, glitch rejection, up/down wraps, tick ignored.
    adj_sel = 1'b1; dir = 1'b0;
    run(2);
    press(10, 10);
    chk("t4_down_wrap_led2", led2, seg_tab[5]);
    dir = 1'b1;
    press(2, 10);
    chk("t3_glitch_led1", led1, seg_tab[9]);
    press(10, 10);
    chk("t3_up_wrap_led1", led1, seg_tab[0]);
    chk("t3_no_carry", equal60, 0);
    chk("t3_disable_hour", disable_hour, 1);
    dir = 1'b0;
    press(8, 8);
    sec_carry = 1'b1; cyc();
    sec_carry = 1'b0; run(3);
    chk("t4_tick_ignored_led1", led1, seg_tab[9]);

    // Scenario 5: advance to 10, then hold the button 60 cycles.
    dir = 1'b1;
    for (int i = 0; i < 11; i++) press(7, 8);
    chk("t5_start_led1", led1, seg_tab[0]);
    btn_n = 1'b0; run(60);
    btn_n = 1'b1; run(10);
`ifndef MINUTE_AUTO_REPEAT_EN
    chk("t5_single_step_led1", led1, seg_tab[1]);
`endif

    // Scenario 6: reset during a held button, then held past reset release.
    btn_n = 1'b0; run(35);
    @(negedge clk50);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_reset_led2", led2, seg_tab[5]);
    chk("t6_reset_led1", led1, seg_tab[9]);
    run(3);
    @(negedge clk50);
    reset = 1'b1;
    run(15);
    btn_n = 1'b1; run(10);

    // Random phase.
    for (int s = 0; s < 160; s++) begin
      int len;
      adj_sel = ($urandom_range(0, 3) != 0);
      dir     = $urandom_range(0, 1);
      btn_n   = $urandom_range(0, 1);
      len     = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        sec_carry = $urandom_range(0, 1);
        if ($urandom_range(0, 40) == 0) adj_sel = ~adj_sel;
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
